// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and helpers for the 2-to-4 stream decoder.
//   buf_state_e     - output buffer occupancy (EMPTY, ONE, FULL)
//   CNT_W_DEFAULT   - default width of the per-code statistics counters
//   decode_onehot() - idle flag + 2-bit code -> 4-bit one-hot word
package decoder_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  localparam int unsigned CNT_W_DEFAULT = 16;

  // Idle words carry no active index and decode to all-zero.
  function automatic logic [3:0] decode_onehot(input logic idle, input logic [1:0] code);
    logic [3:0] word;
    word = '0;
    if (!idle) word[code] = 1'b1;
    return word;
  endfunction

endpackage

// File: rtl/decoder_skid_fifo.sv
// decoder_skid_fifo: 2-entry, 4-bit valid/ready buffer.
//   clk, reset             - rising-edge clock, synchronous active-high reset
//   push_valid/push_ready  - upstream handshake, push_data is the word
//   pop_valid/pop_ready    - downstream handshake, pop_data is the head word
// push_ready is combinational from the state (and low during reset);
// pop_data reads 4'b0000 whenever the buffer is empty.
module decoder_skid_fifo
  import decoder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_valid,
  output logic       push_ready,
  input  logic [3:0] push_data,
  output logic       pop_valid,
  input  logic       pop_ready,
  output logic [3:0] pop_data
);

  buf_state_e state_q, state_d;
  logic [3:0] head_q, head_d;
  logic [3:0] tail_q, tail_d;
  logic       push, pop;

  assign push_ready = !reset && (state_q != FULL);
  assign pop_valid  = (state_q != EMPTY);
  assign pop_data   = pop_valid ? head_q : '0;

  assign push = push_valid && push_ready;
  assign pop  = pop_valid && pop_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = push_data;
          state_d = ONE;
        end
      end
      ONE: begin
        unique case ({push, pop})
          2'b10: begin
            tail_d  = push_data;
            state_d = FULL;
          end
          2'b01: state_d = EMPTY;
          // Head leaves while the new word arrives: the new word becomes head.
          2'b11: head_d = push_data;
          default: ;
        endcase
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/decoder_2to4_stream.sv
// decoder_2to4_stream: registered 2-to-4 one-hot decoder with valid/ready
// stream interface and a 2-entry output buffer.
//   clk, reset           - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    - input handshake; in_data code, in_idle idle flag
//   out_valid/out_ready  - output handshake; out_data one-hot word
//   stat_sel/stat_count  - per-code transfer counter readout
// Optional feature macro: DECODER_STATS_EN enables the four saturating
// per-code counters; without it stat_count is tied to zero.
module decoder_2to4_stream
  import decoder_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_data,
  input  logic             in_idle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  input  logic [1:0]       stat_sel,
  output logic [CNT_W-1:0] stat_count
);

  logic [3:0] decoded;
  logic       in_fire;

  assign decoded = decode_onehot(in_idle, in_data);
  assign in_fire = in_valid && in_ready;

  decoder_skid_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (decoded),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (out_data)
  );

`ifdef DECODER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (in_fire && !in_idle && (in_data == 2'(i)) && (cnt_q[i] != '1))
        cnt_d[i] = cnt_q[i] + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  assign stat_count = cnt_q[stat_sel];
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = ^{stat_sel, in_fire};
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_decoder_2to4_stream.sv
module tb_decoder_2to4_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_data;
  logic        in_idle;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  stat_sel;
  logic [15:0] stat_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_2to4_stream #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_idle    (in_idle),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
  );

`ifdef DECODER_STATS_EN
  logic       in_ready2;
  logic       out_valid2;
  logic [3:0] out_data2;
  logic [1:0] stat_count2;

  decoder_2to4_stream #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready2),
    .in_data    (in_data),
    .in_idle    (in_idle),
    .out_valid  (out_valid2),
    .out_ready  (out_ready),
    .out_data   (out_data2),
    .stat_sel   (stat_sel),
    .stat_count (stat_count2)
  );
`endif

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 2'd2; in_idle = 1'b0;
    out_ready = 1'b1; stat_sel = 2'd0;
    tick(); tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (out_data !== 4'b0000) begin miscompares++; $display("FAIL reset_out_data got %b want 0000", out_data); end
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++;
    if (stat_count !== 16'd0) begin miscompares++; $display("FAIL reset_stat_count got %0d want 0", stat_count); end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 2'd2; in_idle = 1'b0; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
    vectors++;
    if (out_data !== 4'b0100) begin miscompares++; $display("FAIL single_data got %b want 0100", out_data); end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] codes [5];
    logic       idles [5];
    logic [3:0] want  [5];
    codes = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    idles = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    want  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = codes[i]; in_idle = idles[i];
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== want[i]) begin
        miscompares++;
        $display("FAIL b2b_word%0d got v=%b d=%b want v=1 d=%b", i, out_valid, out_data, want[i]);
      end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0; in_idle = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'd1; in_idle = 1'b0;
    tick();
    vectors++;
    if (in_ready !== 1'b1 || out_data !== 4'b0010) begin
      miscompares++; $display("FAIL bp_first got rdy=%b d=%b want rdy=1 d=0010", in_ready, out_data);
    end
    in_data = 2'd3;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 4'b0010) begin
      miscompares++; $display("FAIL bp_hold got v=%b d=%b want v=1 d=0010", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_data !== 4'b1000 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL bp_pop1 got d=%b rdy=%b want d=1000 rdy=1", out_data, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_push_pop_one();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'd2; in_idle = 1'b0;
    tick();
    out_ready = 1'b1; in_data = 2'd0;
    #1;
    vectors++;
    if (out_data !== 4'b0100) begin miscompares++; $display("FAIL pp_popped got %b want 0100", out_data); end
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 4'b0001 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_head got v=%b d=%b rdy=%b want v=1 d=0001 rdy=1", out_valid, out_data, in_ready);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL pp_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 2'd1; in_idle = 1'b0;
    tick();
    in_data = 2'd2;
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 4'b0000) begin
      miscompares++; $display("FAIL rf_reset got v=%b d=%b want v=0 d=0000", out_valid, out_data);
    end
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0 || out_data !== 4'b0000) begin
        miscompares++; $display("FAIL rf_ghost%0d got v=%b d=%b want v=0 d=0000", i, out_valid, out_data);
      end
    end
  endtask

`ifdef DECODER_STATS_EN
  task automatic test_stats();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_data = 2'd1; in_idle = 1'b0;
    repeat (4) tick();
    in_valid = 1'b0;
    stat_sel = 2'd1;
    #1;
    vectors++;
    if (stat_count2 !== 2'd3) begin miscompares++; $display("FAIL stat_sat got %0d want 3", stat_count2); end
    vectors++;
    if (stat_count !== 16'd4) begin miscompares++; $display("FAIL stat_code1 got %0d want 4", stat_count); end
    in_valid = 1'b1; in_data = 2'd3; in_idle = 1'b0;
    repeat (5) tick();
    in_idle = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0; in_idle = 1'b0;
    stat_sel = 2'd3;
    #1;
    vectors++;
    if (stat_count !== 16'd5) begin miscompares++; $display("FAIL stat_code3 got %0d want 5", stat_count); end
    vectors++;
    if (stat_count2 !== 2'd3) begin miscompares++; $display("FAIL stat_code3_narrow got %0d want 3", stat_count2); end
    stat_sel = 2'd0;
    #1;
    vectors++;
    if (stat_count !== 16'd0) begin miscompares++; $display("FAIL stat_code0 got %0d want 0", stat_count); end
  endtask
`else
  task automatic test_stats();
    in_valid = 1'b1; in_data = 2'd3; in_idle = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      stat_sel = 2'(s);
      #1;
      vectors++;
      if (stat_count !== 16'd0) begin miscompares++; $display("FAIL stat_off%0d got %0d want 0", s, stat_count); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop_one();
    test_reset_full();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
